// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package sseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef enum logic {GUARD, LIT} slot_phase_t;

endpackage

// File: rtl/hex_to_sseg.sv
// Active-high hex-to-seven-segment decoder; dp passes straight to the DP bit.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);

    logic [6:0] seg;

    always_comb begin
        case (hex)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        sseg               = SEG_OFF;
        sseg[SEG_G:SEG_A]  = seg;
        sseg[SEG_DP]       = dp;
    end

endmodule

// File: rtl/sseg_mux_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-atomic digit updates.
// Optional build macro SSEG_LEADING_ZERO_BLANK_EN darkens leading zero digits.
module sseg_mux_ctrl
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DWELL_BITS   = 16,
    parameter int GUARD_CYCLES = 64,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [4*N_DIGITS-1:0] wr_hex,
    input  logic [N_DIGITS-1:0]   wr_dp,
    output logic                  pending,
    output logic                  frame_tick,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg
);

    localparam int                    IW            = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0]         IDX_LAST      = IW'(N_DIGITS - 1);
    localparam logic [DWELL_BITS-1:0] GUARD_END     = DWELL_BITS'(GUARD_CYCLES);
    localparam slot_phase_t           PHASE_AT_ZERO = (GUARD_CYCLES == 0) ? LIT : GUARD;
    localparam logic [N_DIGITS-1:0]   AN_ONE        = 1;
    localparam logic [N_DIGITS-1:0]   AN_POL        = {N_DIGITS{ACTIVE_LOW}};
    localparam logic [7:0]            SSEG_POL      = {8{ACTIVE_LOW}};

    logic [DWELL_BITS-1:0] cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    slot_phase_t           phase_q;
    logic [4*N_DIGITS-1:0] shadow_hex_q, disp_hex_q;
    logic [N_DIGITS-1:0]   shadow_dp_q, disp_dp_q;
    logic                  pending_q, frame_tick_q;
    logic [N_DIGITS-1:0]   an_q;
    logic [7:0]            sseg_q;

    logic                  cnt_wrap, boundary, blank;
    logic [3:0]            sel_hex;
    logic                  sel_dp;
    logic [7:0]            dec_sseg, lit_sseg;

    assign cnt_d    = cnt_q + 1'b1;
    assign cnt_wrap = &cnt_q;
    assign boundary = cnt_wrap && (idx_q == IDX_LAST);

    always_comb begin
        idx_d = idx_q;
        if (cnt_wrap)
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    assign sel_hex = disp_hex_q[idx_q*4 +: 4];
    assign sel_dp  = disp_dp_q[idx_q];

    hex_to_sseg u_dec (
        .hex  (sel_hex),
        .dp   (sel_dp),
        .sseg (dec_sseg)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    // lead_zero[k]: every nibble from the top digit down to k is zero
    logic [N_DIGITS-1:0] lead_zero;
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        lead_zero   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zeros_above  = zeros_above && (disp_hex_q[4*k +: 4] == 4'h0);
            lead_zero[k] = zeros_above;
        end
    end
    assign blank = (idx_q != '0) && lead_zero[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        lit_sseg = dec_sseg;
        if (blank)
            lit_sseg[SEG_G:SEG_A] = SEG_OFF[SEG_G:SEG_A];
    end

    // Slot scheduler; phase_q tracks cnt_q >= GUARD_CYCLES one register ahead of the pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            phase_q      <= PHASE_AT_ZERO;
            frame_tick_q <= 1'b0;
            an_q         <= AN_POL;
            sseg_q       <= SEG_OFF ^ SSEG_POL;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            case (phase_q)
                GUARD:   if (cnt_d == GUARD_END) phase_q <= LIT;
                LIT:     if (cnt_wrap) phase_q <= PHASE_AT_ZERO;
                default: phase_q <= GUARD;
            endcase
            frame_tick_q <= (cnt_q == '0) && (idx_q == '0);
            if (phase_q == LIT) begin
                an_q   <= (AN_ONE << idx_q) ^ AN_POL;
                sseg_q <= lit_sseg ^ SSEG_POL;
            end else begin
                an_q   <= AN_POL;
                sseg_q <= SEG_OFF ^ SSEG_POL;
            end
        end
    end

    // A write landing on the boundary bypasses shadow so it shows this frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_hex_q <= '0;
            shadow_dp_q  <= '0;
            disp_hex_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
        end else if (boundary) begin
            if (wr_en) begin
                disp_hex_q <= wr_hex;
                disp_dp_q  <= wr_dp;
            end else if (pending_q) begin
                disp_hex_q <= shadow_hex_q;
                disp_dp_q  <= shadow_dp_q;
            end
            pending_q <= 1'b0;
        end else if (wr_en) begin
            shadow_hex_q <= wr_hex;
            shadow_dp_q  <= wr_dp;
            pending_q    <= 1'b1;
        end
    end

    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;
    assign an         = an_q;
    assign sseg       = sseg_q;

endmodule

// File: tb/tb_sseg_mux_ctrl.sv
// Scoreboard bench for sseg_mux_ctrl: 4 digits, 16-cycle slots, 2-cycle guard, active-high pins.
module tb_sseg_mux_ctrl;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        wr_en  = 1'b0;
    logic [15:0] wr_hex = '0;
    logic [3:0]  wr_dp  = '0;
    logic        pending, frame_tick;
    logic [3:0]  an;
    logic [7:0]  sseg;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] Z = 8'h00;
`else
    localparam logic [7:0] Z = 8'h3F;
`endif

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
    } exp_t;

    exp_t sb_q[$];
    int   nvec = 0;
    int   nerr = 0;

    sseg_mux_ctrl #(
        .N_DIGITS     (4),
        .DWELL_BITS   (4),
        .GUARD_CYCLES (2),
        .ACTIVE_LOW   (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_hex     (wr_hex),
        .wr_dp      (wr_dp),
        .pending    (pending),
        .frame_tick (frame_tick),
        .an         (an),
        .sseg       (sseg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
        sb_q.push_back({4'b0001, s0});
        sb_q.push_back({4'b0010, s1});
        sb_q.push_back({4'b0100, s2});
        sb_q.push_back({4'b1000, s3});
    endtask

    // Each step lands on a negedge; a write strobe lasts exactly one clock
    task automatic adv(input int k);
        repeat (k) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic wr(input logic [15:0] hex, input logic [3:0] dp);
        wr_en  = 1'b1;
        wr_hex = hex;
        wr_dp  = dp;
    endtask

    // Returns on the cycle frame_tick is high (frame position p=1)
    task automatic sync_frame();
        int n;
        n = 0;
        do begin
            adv(1);
            n++;
        end while (!frame_tick && n < 100);
        chk("frame_tick_seen", 32'(frame_tick), 32'd1);
    endtask

    // Monitor: pop one expectation at the first lit cycle of every slot
    initial begin
        int   cyc;
        int   last_tick;
        logic prev_lit;
        exp_t e;
        cyc       = 0;
        last_tick = -1;
        prev_lit  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_lit  = 1'b0;
                last_tick = -1;
            end else begin
                if (frame_tick) begin
                    if (last_tick >= 0)
                        chk("tick_period", 32'(cyc - last_tick), 32'd64);
                    last_tick = cyc;
                end
                if (an != 4'b0000 && !prev_lit) begin
                    if (sb_q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected_slot: got an=%b sseg=0x%0h, want nothing at %0t",
                                 an, sseg, $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("slot_an", 32'(an), 32'(e.an));
                        chk("slot_sseg", 32'(sseg), 32'(e.sseg));
                    end
                end
                prev_lit = (an != 4'b0000);
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 5000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_sseg", 32'(sseg), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);

        // Reset release, nothing written: zeros on every digit
        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        reset = 1'b0;
        sync_frame();                                   // p=1
        chk("guard_p1_an", 32'(an), 32'h0);
        adv(1);                                         // p=2
        chk("guard_p2_an", 32'(an), 32'h0);
        chk("guard_p2_sseg", 32'(sseg), 32'h0);
        chk("tick_width", 32'(frame_tick), 32'h0);
        adv(1);                                         // p=3
        chk("first_lit_an", 32'(an), 32'h1);

        // Write mid-frame, shown from the next frame on
        adv(17);                                        // p=20
        wr(16'h1234, 4'b0000);
        push_frame(8'h66, 8'h4F, 8'h5B, 8'h06);
        adv(1);
        chk("pend_set", 32'(pending), 32'h1);
        adv(42);                                        // p=63, boundary cycle
        chk("pend_hold", 32'(pending), 32'h1);
        adv(1);
        chk("pend_clr", 32'(pending), 32'h0);

        // Two writes in one frame: the last one wins
        sync_frame();
        adv(9);                                         // p=10
        wr(16'hAAAA, 4'b0000);
        adv(20);                                        // p=30
        wr(16'h5555, 4'b0000);
        push_frame(8'h6D, 8'h6D, 8'h6D, 8'h6D);
        adv(1);
        chk("pend_rewrite", 32'(pending), 32'h1);

        // Write on the boundary cycle goes straight to display
        sync_frame();
        adv(62);                                        // p=63
        wr(16'h0008, 4'b0000);
        push_frame(8'h7F, 8'h3F, 8'h3F, 8'h3F);
        adv(1);
        chk("bnd_pend0", 32'(pending), 32'h0);
        sync_frame();
        chk("bnd_pend1", 32'(pending), 32'h0);

        // Reset while slot 2 is lit, with a write still pending
        adv(35);                                        // p=36
        wr(16'hFFFF, 4'b1111);
        adv(1);
        chk("pre_rst_pend", 32'(pending), 32'h1);
        adv(3);                                         // p=40
        chk("pre_rst_an", 32'(an), 32'h4);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_an", 32'(an), 32'h0);
        chk("async_rst_sseg", 32'(sseg), 32'h0);
        chk("async_rst_pend", 32'(pending), 32'h0);
        sb_q.delete();
        push_frame(8'h3F, 8'h3F, 8'h3F, 8'h3F);
        @(negedge clk);
        reset = 1'b0;
        adv(1);
        chk("restart_tick", 32'(frame_tick), 32'h1);
        adv(2);                                         // p=3
        chk("restart_an", 32'(an), 32'h1);
        chk("restart_pend", 32'(pending), 32'h0);

        // Leading zeros: dark only when the macro is enabled
        adv(17);                                        // p=20
        wr(16'h0012, 4'b0000);
        push_frame(8'h5B, 8'h06, Z, Z);
        sync_frame();
        adv(19);
        wr(16'h0000, 4'b0000);
        push_frame(8'h3F, Z, Z, Z);
        sync_frame();
        adv(19);
        wr(16'h0000, 4'b1000);
        push_frame(8'h3F, Z, Z, Z | 8'h80);
        sync_frame();
        adv(19);
        wr(16'h1020, 4'b0010);
        push_frame(8'h3F, 8'hDB, 8'h3F, 8'h06);
        sync_frame();
        adv(64);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
